// File: rtl/l2_port_arbiter_pkg.sv
// Shared constants and types for the L1-to-L2 port arbiter.
package l2_port_arbiter_pkg;

    localparam int DEF_ADDR_WIDTH   = 32;
    localparam int DEF_LINE_WIDTH   = 256;
    localparam int DEF_MSHR_ID_BITS = 3;

    localparam int   PORT_BITS = 1;
    localparam logic PORT_I    = 1'b0;   // instruction L1
    localparam logic PORT_D    = 1'b1;   // data L1

    // Request bundle as seen by L2 at the default widths: {addr, data, rw, id}
    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0]             addr;
        logic [DEF_LINE_WIDTH-1:0]             data;
        logic                                  rw;
        logic [DEF_MSHR_ID_BITS+PORT_BITS-1:0] id;
    } l2_req_t;

    // The round-robin winner when both ports compete is the one not served last
    function automatic logic other_port(input logic p);
        return ~p;
    endfunction

endpackage

// File: rtl/l2_port_arbiter_if.sv
// L1 requester port bundle and L2 port bundle.
interface l1_req_if
    import l2_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int LINE_WIDTH   = DEF_LINE_WIDTH,
    parameter int MSHR_ID_BITS = DEF_MSHR_ID_BITS
);
    logic [ADDR_WIDTH-1:0]   addr;
    logic [LINE_WIDTH-1:0]   data;
    logic                    rw;
    logic                    valid;
    logic [MSHR_ID_BITS-1:0] id;
    logic                    stall;
    logic [LINE_WIDTH-1:0]   rsp_data;
    logic [MSHR_ID_BITS-1:0] rsp_id;
    logic                    ready;

    // L1 cache side
    modport master (output addr, data, rw, valid, id,
                    input  stall, rsp_data, rsp_id, ready);
    // Arbiter side
    modport slave  (input  addr, data, rw, valid, id,
                    output stall, rsp_data, rsp_id, ready);
endinterface

interface l2_bus_if
    import l2_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int LINE_WIDTH   = DEF_LINE_WIDTH,
    parameter int MSHR_ID_BITS = DEF_MSHR_ID_BITS
);
    logic [ADDR_WIDTH-1:0]   addr;
    logic [LINE_WIDTH-1:0]   data;
    logic                    rw;
    logic                    valid;
    logic [MSHR_ID_BITS:0]   id;
    logic                    stall;
    logic [LINE_WIDTH-1:0]   rsp_data;
    logic [MSHR_ID_BITS:0]   rsp_id;
    logic                    ready;

    // Arbiter side
    modport master (output addr, data, rw, valid, id,
                    input  stall, rsp_data, rsp_id, ready);
    // L2 cache side
    modport slave  (input  addr, data, rw, valid, id,
                    output stall, rsp_data, rsp_id, ready);
endinterface

// File: rtl/l2_port_arbiter_slot.sv
// One-entry request holding register with full flag.
// Capture only when empty; clear on grant. Capture and clear never coincide
// because clear needs a full slot and capture needs an empty one.
module l2_req_slot #(
    parameter int ADDR_WIDTH   = 32,
    parameter int LINE_WIDTH   = 256,
    parameter int MSHR_ID_BITS = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cap_i,
    input  logic                    clr_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [LINE_WIDTH-1:0]   data_i,
    input  logic                    rw_i,
    input  logic [MSHR_ID_BITS-1:0] id_i,
    output logic                    full_o,
    output logic [ADDR_WIDTH-1:0]   addr_o,
    output logic [LINE_WIDTH-1:0]   data_o,
    output logic                    rw_o,
    output logic [MSHR_ID_BITS-1:0] id_o
);
    logic                    full_q, full_d;
    logic                    load;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LINE_WIDTH-1:0]   data_q;
    logic                    rw_q;
    logic [MSHR_ID_BITS-1:0] id_q;

    // A pulse arriving while full is an L1 protocol error and is dropped
    assign load = cap_i && !full_q;

    // Next-state of the occupancy flag
    always_comb begin
        full_d = full_q;
        if (clr_i)
            full_d = 1'b0;
        else if (load)
            full_d = 1'b1;
    end

    // Occupancy flag; reset empties the slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            full_q <= 1'b0;
        else
            full_q <= full_d;
    end

    // Payload is only meaningful while full, so it carries no reset
    always_ff @(posedge clk) begin
        if (load) begin
            addr_q <= addr_i;
            data_q <= data_i;
            rw_q   <= rw_i;
            id_q   <= id_i;
        end
    end

    assign full_o = full_q;
    assign addr_o = addr_q;
    assign data_o = data_q;
    assign rw_o   = rw_q;
    assign id_o   = id_q;

endmodule

// File: rtl/l2_port_arbiter.sv
// Shares the single L2 request/response port between the instruction L1
// (port 0) and data L1 (port 1). Round-robin grant, port number carried in
// the L2 id MSB, responses steered back by that MSB.
module l2_port_arbiter
    import l2_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int LINE_WIDTH   = DEF_LINE_WIDTH,
    parameter int MSHR_ID_BITS = DEF_MSHR_ID_BITS
) (
    input  logic      clk,
    input  logic      reset,
    l1_req_if.slave   rq0,
    l1_req_if.slave   rq1,
    l2_bus_if.master  l2
);
    localparam int ID_W = MSHR_ID_BITS + PORT_BITS;

    logic                    full0, full1;
    logic [ADDR_WIDTH-1:0]   s0_addr, s1_addr;
    logic [LINE_WIDTH-1:0]   s0_data, s1_data;
    logic                    s0_rw, s1_rw;
    logic [MSHR_ID_BITS-1:0] s0_id, s1_id;

    logic                    any_gnt, gnt_port, gnt0, gnt1;
    logic                    rr_q, rr_d;

    logic                    l2_valid_q, l2_valid_d;
    logic [ADDR_WIDTH-1:0]   l2_addr_q, l2_addr_d;
    logic [LINE_WIDTH-1:0]   l2_data_q, l2_data_d;
    logic                    l2_rw_q, l2_rw_d;
    logic [ID_W-1:0]         l2_id_q, l2_id_d;

    logic                    rsp_port;
    logic                    rdy0_q, rdy0_d, rdy1_q, rdy1_d;
    logic [LINE_WIDTH-1:0]   rsp0_data_q, rsp0_data_d, rsp1_data_q, rsp1_data_d;
    logic [MSHR_ID_BITS-1:0] rsp0_id_q, rsp0_id_d, rsp1_id_q, rsp1_id_d;

    l2_req_slot #(
        .ADDR_WIDTH(ADDR_WIDTH), .LINE_WIDTH(LINE_WIDTH), .MSHR_ID_BITS(MSHR_ID_BITS)
    ) u_slot0 (
        .clk(clk), .reset(reset), .cap_i(rq0.valid), .clr_i(gnt0),
        .addr_i(rq0.addr), .data_i(rq0.data), .rw_i(rq0.rw), .id_i(rq0.id),
        .full_o(full0), .addr_o(s0_addr), .data_o(s0_data), .rw_o(s0_rw), .id_o(s0_id)
    );

    l2_req_slot #(
        .ADDR_WIDTH(ADDR_WIDTH), .LINE_WIDTH(LINE_WIDTH), .MSHR_ID_BITS(MSHR_ID_BITS)
    ) u_slot1 (
        .clk(clk), .reset(reset), .cap_i(rq1.valid), .clr_i(gnt1),
        .addr_i(rq1.addr), .data_i(rq1.data), .rw_i(rq1.rw), .id_i(rq1.id),
        .full_o(full1), .addr_o(s1_addr), .data_o(s1_data), .rw_o(s1_rw), .id_o(s1_id)
    );

    // Grant selection: a lone full slot wins; on contention the port not served last wins
    always_comb begin
        any_gnt  = (full0 || full1) && !l2.stall;
        gnt_port = full1 ? PORT_D : PORT_I;
        if (full0 && full1)
            gnt_port = other_port(rr_q);
        gnt0 = any_gnt && (gnt_port == PORT_I);
        gnt1 = any_gnt && (gnt_port == PORT_D);
        rr_d = any_gnt ? gnt_port : rr_q;
    end

    // Forwarded request fields: load from the granted slot, otherwise hold
    always_comb begin
        l2_valid_d = any_gnt;
        l2_addr_d  = l2_addr_q;
        l2_data_d  = l2_data_q;
        l2_rw_d    = l2_rw_q;
        l2_id_d    = l2_id_q;
        if (gnt0) begin
            l2_addr_d = s0_addr;
            l2_data_d = s0_data;
            l2_rw_d   = s0_rw;
            l2_id_d   = {PORT_I, s0_id};
        end else if (gnt1) begin
            l2_addr_d = s1_addr;
            l2_data_d = s1_data;
            l2_rw_d   = s1_rw;
            l2_id_d   = {PORT_D, s1_id};
        end
    end

    // Request output register and round-robin pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q       <= PORT_I;
            l2_valid_q <= 1'b0;
            l2_addr_q  <= '0;
            l2_data_q  <= '0;
            l2_rw_q    <= 1'b0;
            l2_id_q    <= '0;
        end else begin
            rr_q       <= rr_d;
            l2_valid_q <= l2_valid_d;
            l2_addr_q  <= l2_addr_d;
            l2_data_q  <= l2_data_d;
            l2_rw_q    <= l2_rw_d;
            l2_id_q    <= l2_id_d;
        end
    end

    assign rsp_port = l2.rsp_id[MSHR_ID_BITS];

    // Response demux: only the owning port sees the pulse; the other holds its data/id
    always_comb begin
        rdy0_d      = l2.ready && (rsp_port == PORT_I);
        rdy1_d      = l2.ready && (rsp_port == PORT_D);
        rsp0_data_d = rsp0_data_q;
        rsp0_id_d   = rsp0_id_q;
        rsp1_data_d = rsp1_data_q;
        rsp1_id_d   = rsp1_id_q;
        if (rdy0_d) begin
            rsp0_data_d = l2.rsp_data;
            rsp0_id_d   = l2.rsp_id[MSHR_ID_BITS-1:0];
        end
        if (rdy1_d) begin
            rsp1_data_d = l2.rsp_data;
            rsp1_id_d   = l2.rsp_id[MSHR_ID_BITS-1:0];
        end
    end

    // Response output registers; an in-flight response is dropped by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy0_q      <= 1'b0;
            rdy1_q      <= 1'b0;
            rsp0_data_q <= '0;
            rsp0_id_q   <= '0;
            rsp1_data_q <= '0;
            rsp1_id_q   <= '0;
        end else begin
            rdy0_q      <= rdy0_d;
            rdy1_q      <= rdy1_d;
            rsp0_data_q <= rsp0_data_d;
            rsp0_id_q   <= rsp0_id_d;
            rsp1_data_q <= rsp1_data_d;
            rsp1_id_q   <= rsp1_id_d;
        end
    end

    // Stall is forced high during reset so no L1 pulses into a slot being cleared
    assign rq0.stall    = full0 | reset;
    assign rq1.stall    = full1 | reset;
    assign rq0.rsp_data = rsp0_data_q;
    assign rq0.rsp_id   = rsp0_id_q;
    assign rq0.ready    = rdy0_q;
    assign rq1.rsp_data = rsp1_data_q;
    assign rq1.rsp_id   = rsp1_id_q;
    assign rq1.ready    = rdy1_q;

    assign l2.valid = l2_valid_q;
    assign l2.addr  = l2_addr_q;
    assign l2.data  = l2_data_q;
    assign l2.rw    = l2_rw_q;
    assign l2.id    = l2_id_q;

endmodule
